// File: rtl/shift_frame_tx_ctrl_pkg.sv
// Shared types for the frame serializer controller.
// Latency: none (types only).
// Backpressure: none (types only).
package shift_frame_pkg;

    // Controller states. The encoding is fixed so state values stay stable across revisions.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int STATE_W = 2;

endpackage

// File: rtl/shift_frame_tx_ctrl_if.sv
// Word-source, shift-register and serial-line signals of the frame serializer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the word side; the serial side has none.
interface shift_frame_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             abort;
    logic             sr_enable;
    logic             sr_sclr;
    logic             sr_load;
    logic [WIDTH-1:0] sr_data;
    logic             sr_shiftin;
    logic             sr_shiftout;
    logic             tx_bit;
    logic             tx_valid;
    logic             done;

    // Word source plus shift register, as seen from outside the controller.
    modport master (
        output in_valid, in_data, abort, sr_shiftout,
        input  in_ready, sr_enable, sr_sclr, sr_load, sr_data, sr_shiftin,
        input  tx_bit, tx_valid, done
    );

    // The controller itself.
    modport slave (
        input  in_valid, in_data, abort, sr_shiftout,
        output in_ready, sr_enable, sr_sclr, sr_load, sr_data, sr_shiftin,
        output tx_bit, tx_valid, done
    );
endinterface

// File: rtl/shift_frame_tx_ctrl_bit_tick_gen.sv
// Bit-rate divider: tick marks the first clock of every CLKS_PER_BIT-clock bit slot while run is high.
// Latency: tick is asserted in the first cycle run is high; wrap marks the last cycle of each slot.
// Backpressure: none; the counter returns to 0 whenever run is low.
module bit_tick_gen #(
    parameter int DIV_W        = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic sclr,
    input  logic run,
    output logic tick,
    output logic wrap
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = run && (div_q == '0);
    assign wrap = run && (div_q == DIV_LAST);

    // Next divider value: count while running, wrap at the end of a slot, hold 0 when idle.
    always_comb begin
        div_d = '0;
        if (run && !wrap) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clock) begin
        if (sclr) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/shift_frame_tx_ctrl.sv
// Loads a parallel word into an external shift register, then shifts it out one bit per CLKS_PER_BIT clocks.
// Latency: first serial bit valid 2 cycles after the handshake; one word every WIDTH*CLKS_PER_BIT+2 cycles.
// Backpressure: in_ready is high only in IDLE, so the source is held off for the whole frame.
module shift_frame_tx_ctrl
    import shift_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit FILL_BIT     = 1'b0
) (
    input  logic                  clock,
    input  logic                  sclr,
    shift_frame_tx_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             tx_valid_q;
    logic             tx_valid_d;

    logic run;
    logic tick;
    logic wrap;
    logic in_ready;
    logic sr_enable;
    logic sr_sclr;
    logic sr_load;
    logic done;

    // The divider only runs in SHIFT, so every frame starts with a shift pulse one cycle after the load.
    assign run = (state_q == ST_SHIFT);

    bit_tick_gen #(
        .DIV_W        (DIV_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick_gen (
        .clock (clock),
        .sclr  (sclr),
        .run   (run),
        .tick  (tick),
        .wrap  (wrap)
    );

    // Next state, bit count and shift-register control decode; sclr overrides everything.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = '0;
        tx_valid_d = 1'b0;
        in_ready   = 1'b0;
        sr_enable  = 1'b0;
        sr_sclr    = 1'b0;
        sr_load    = 1'b0;
        done       = 1'b0;
        if (sclr) begin
            // Clear the shift register in the same cycle as the controller.
            state_d   = ST_IDLE;
            sr_sclr   = 1'b1;
            sr_enable = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    in_ready = 1'b1;
                    if (bus.in_valid) begin
                        sr_load   = 1'b1;
                        sr_enable = 1'b1;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.abort) begin
                        // Drop the frame: clear the register, no done pulse.
                        sr_sclr   = 1'b1;
                        sr_enable = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        sr_enable  = tick;
                        tx_valid_d = 1'b1;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(tick);
                        // Leave once the last bit has been held for its full slot.
                        if (wrap && (bit_cnt_d == CNT_W'(WIDTH))) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    done      = 1'b1;
                    sr_sclr   = 1'b1;
                    sr_enable = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, bit counter and line-valid registers.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.sr_enable  = sr_enable;
    assign bus.sr_sclr    = sr_sclr;
    assign bus.sr_load    = sr_load;
    assign bus.sr_data    = bus.in_data;
    assign bus.sr_shiftin = FILL_BIT;
    assign bus.tx_bit     = tx_valid_q & bus.sr_shiftout;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.done       = done;

endmodule

// File: tb/tb_shift_frame_tx_ctrl.sv
// Bench for the frame serializer: an 8-bit/4-clock instance and a 1-bit/1-clock instance,
// each driving a left-shifting register model; expected line bits and done cycles are queued
// at handshake time and consumed by per-instance monitors.
module tb_shift_frame_tx_ctrl;

    logic clk = 1'b0;
    logic sclr;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_en = 1'b0;

    bit a_bitq[$];
    int a_doneq[$];
    bit b_bitq[$];
    int b_doneq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_frame_tx_ctrl_if #(.WIDTH(8)) a_if ();
    shift_frame_tx_ctrl_if #(.WIDTH(1)) b_if ();

    shift_frame_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(4), .FILL_BIT(1'b0)) dut_a (
        .clock (clk),
        .sclr  (sclr),
        .bus   (a_if.slave)
    );

    shift_frame_tx_ctrl #(.WIDTH(1), .CLKS_PER_BIT(1), .FILL_BIT(1'b0)) dut_b (
        .clock (clk),
        .sclr  (sclr),
        .bus   (b_if.slave)
    );

    // Left-shifting register models; shiftout is registered and takes the MSB on each shift.
    logic [7:0] a_q;
    logic       a_so;
    logic       b_q;
    logic       b_so;

    always @(posedge clk) begin
        if (a_if.sr_enable) begin
            if (a_if.sr_sclr) begin
                a_q  <= '0;
                a_so <= 1'b0;
            end else if (a_if.sr_load) begin
                a_q <= a_if.sr_data;
            end else begin
                a_so <= a_q[7];
                a_q  <= {a_q[6:0], a_if.sr_shiftin};
            end
        end
        if (b_if.sr_enable) begin
            if (b_if.sr_sclr) begin
                b_q  <= 1'b0;
                b_so <= 1'b0;
            end else if (b_if.sr_load) begin
                b_q <= b_if.sr_data[0];
            end else begin
                b_so <= b_q;
                b_q  <= b_if.sr_shiftin;
            end
        end
    end

    assign a_if.sr_shiftout = a_so;
    assign b_if.sr_shiftout = b_so;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors: every line-valid cycle consumes one expected bit, every done consumes one expected cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_if.tx_valid === 1'b1) begin
                if (a_bitq.size() == 0) chk("a tx_valid with no frame pending", a_if.tx_valid, 1'b0);
                else chk("a tx_bit", a_if.tx_bit, a_bitq.pop_front());
            end else begin
                chk("a tx_bit low while idle", a_if.tx_bit, 1'b0);
            end
            if (a_if.done === 1'b1) begin
                if (a_doneq.size() == 0) chk("a done with no frame pending", a_if.done, 1'b0);
                else chk("a done cycle", cyc, a_doneq.pop_front());
            end
            if (b_if.tx_valid === 1'b1) begin
                if (b_bitq.size() == 0) chk("b tx_valid with no frame pending", b_if.tx_valid, 1'b0);
                else chk("b tx_bit", b_if.tx_bit, b_bitq.pop_front());
            end
            if (b_if.done === 1'b1) begin
                if (b_doneq.size() == 0) chk("b done with no frame pending", b_if.done, 1'b0);
                else chk("b done cycle", cyc, b_doneq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Wait until the negedge of cycle n.
    task automatic at_neg(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // Return just after the posedge that starts cycle n.
    task automatic drive_in(input int n);
        at_neg(n - 1);
        @(posedge clk);
        #1;
    endtask

    // Offer a word on the 8-bit instance and queue what the line should carry.
    task automatic a_send(input logic [7:0] d, input int nvalid, input bit exp_done,
                          input bit hold, output int t0);
        int guard;
        guard = 0;
        a_if.in_data  = d;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        while (!a_if.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("a in_ready for handshake", a_if.in_ready, 1'b1);
        t0 = cyc;
        chk("a sr_load at T0", a_if.sr_load, 1'b1);
        chk("a sr_enable at T0", a_if.sr_enable, 1'b1);
        chk("a sr_sclr low at T0", a_if.sr_sclr, 1'b0);
        chk("a sr_data at T0", a_if.sr_data, d);
        chk("a tx_valid low at T0", a_if.tx_valid, 1'b0);
        for (int i = 0; i < nvalid; i++) a_bitq.push_back(d[7 - i / 4]);
        if (exp_done) a_doneq.push_back(t0 + 33);
        @(posedge clk);
        #1;
        a_if.abort = 1'b0;
        if (!hold) a_if.in_valid = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        int extra;
        sclr          = 1'b1;
        a_if.in_valid = 1'b0;
        a_if.in_data  = '0;
        a_if.abort    = 1'b0;
        b_if.in_valid = 1'b0;
        b_if.in_data  = '0;
        b_if.abort    = 1'b0;

        // Reset: two cycles of sclr.
        repeat (2) begin
            @(negedge clk);
            chk("rst a in_ready", a_if.in_ready, 1'b0);
            chk("rst a sr_sclr", a_if.sr_sclr, 1'b1);
            chk("rst a sr_enable", a_if.sr_enable, 1'b1);
            chk("rst a tx_valid", a_if.tx_valid, 1'b0);
            chk("rst a done", a_if.done, 1'b0);
            chk("rst b in_ready", b_if.in_ready, 1'b0);
            mon_en = 1'b1;
            @(posedge clk);
            #1;
        end
        sclr = 1'b0;
        @(negedge clk);
        chk("a in_ready after reset", a_if.in_ready, 1'b1);
        chk("b in_ready after reset", b_if.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 1: single A5 frame with exact edges.
        a_send(8'hA5, 32, 1'b1, 1'b0, t0);
        at_neg(t0 + 1);  chk("t1 tx_valid low at T1", a_if.tx_valid, 1'b0);
        at_neg(t0 + 2);  chk("t1 tx_valid high at T2", a_if.tx_valid, 1'b1);
        at_neg(t0 + 33); chk("t1 tx_valid high at T33", a_if.tx_valid, 1'b1);
        chk("t1 in_ready low at T33", a_if.in_ready, 1'b0);
        chk("t1 sr_sclr at T33", a_if.sr_sclr, 1'b1);
        at_neg(t0 + 34); chk("t1 in_ready at T34", a_if.in_ready, 1'b1);
        chk("t1 tx_valid low at T34", a_if.tx_valid, 1'b0);
        @(posedge clk);
        #1;

        // 2: back-to-back FF then 00 with in_valid held.
        a_send(8'hFF, 32, 1'b1, 1'b1, t0);
        a_send(8'h00, 32, 1'b1, 1'b0, t1);
        chk("t2 second handshake offset", t1 - t0, 34);
        at_neg(t1 + 1); chk("t2 gap tx_valid low", a_if.tx_valid, 1'b0);
        at_neg(t1 + 2); chk("t2 second frame tx_valid", a_if.tx_valid, 1'b1);
        at_neg(t1 + 34);
        @(posedge clk);
        #1;

        // 3: abort at T10 during C3.
        a_send(8'hC3, 9, 1'b0, 1'b0, t0);
        drive_in(t0 + 10);
        a_if.abort = 1'b1;
        @(negedge clk);
        chk("t3 sr_sclr on abort", a_if.sr_sclr, 1'b1);
        chk("t3 sr_enable on abort", a_if.sr_enable, 1'b1);
        chk("t3 sr_load low on abort", a_if.sr_load, 1'b0);
        @(posedge clk);
        #1;
        a_if.abort = 1'b0;
        @(negedge clk);
        chk("t3 tx_valid low at T11", a_if.tx_valid, 1'b0);
        chk("t3 in_ready at T11", a_if.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 4: sclr at T20 mid-frame, then a normal frame (abort held in IDLE is ignored).
        a_send(8'h5A, 19, 1'b0, 1'b0, t0);
        drive_in(t0 + 20);
        sclr = 1'b1;
        @(negedge clk);
        chk("t4 sr_sclr during sclr", a_if.sr_sclr, 1'b1);
        chk("t4 in_ready low during sclr", a_if.in_ready, 1'b0);
        @(posedge clk);
        #1;
        sclr = 1'b0;
        @(negedge clk);
        chk("t4 tx_valid at T21", a_if.tx_valid, 1'b0);
        chk("t4 done at T21", a_if.done, 1'b0);
        chk("t4 sr_enable at T21", a_if.sr_enable, 1'b0);
        chk("t4 in_ready at T21", a_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        a_if.abort = 1'b1;
        a_send(8'h3C, 32, 1'b1, 1'b0, t0);
        at_neg(t0 + 34);
        @(posedge clk);
        #1;

        // 6: in_valid toggling during SHIFT must not reload.
        a_send(8'h96, 32, 1'b1, 1'b0, t0);
        extra = 0;
        for (int k = 1; k <= 30; k++) begin
            a_if.in_valid = k[0];
            a_if.in_data  = 8'($urandom);
            @(negedge clk);
            if (a_if.sr_load === 1'b1) extra++;
            @(posedge clk);
            #1;
        end
        a_if.in_valid = 1'b0;
        chk("t6 no extra sr_load", extra, 0);
        at_neg(t0 + 34);
        @(posedge clk);
        #1;

        // 5: one-bit word at one clock per bit.
        b_if.in_data  = 1'b1;
        b_if.in_valid = 1'b1;
        @(negedge clk);
        chk("t5 b in_ready", b_if.in_ready, 1'b1);
        chk("t5 b sr_load at T0", b_if.sr_load, 1'b1);
        t0 = cyc;
        b_bitq.push_back(1'b1);
        b_doneq.push_back(t0 + 2);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        at_neg(t0 + 1); chk("t5 b tx_valid low at T1", b_if.tx_valid, 1'b0);
        at_neg(t0 + 2); chk("t5 b tx_valid at T2", b_if.tx_valid, 1'b1);
        chk("t5 b in_ready low at T2", b_if.in_ready, 1'b0);
        at_neg(t0 + 3); chk("t5 b tx_valid low at T3", b_if.tx_valid, 1'b0);
        chk("t5 b in_ready at T3", b_if.in_ready, 1'b1);

        repeat (5) @(negedge clk);
        chk("a bits all consumed", a_bitq.size(), 0);
        chk("a done pulses all seen", a_doneq.size(), 0);
        chk("b bits all consumed", b_bitq.size(), 0);
        chk("b done pulses all seen", b_doneq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
